z16_instr_encoder: RTL and testbench

Streaming Z16 instruction encoder and program loader. It accepts decoded instruction fields (opcode, register addresses, immediate) over a valid/ready handshake and packs them into 16-bit Z16 instruction words. It range-checks the fields and writes the words at consecutive addresses into instruction memory through a 2-entry output buffer. It sits between the host/debug load path and the instruction RAM, producing exactly the bit layout the core's decoder consumes.

---
 rtl/z16_instr_encoder.sv | 168 ++++++++++++++++
 tb/tb_z16_instr_encoder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z16_instr_encoder.sv
// rtl/z16_instr_encoder.sv - Z16 field-to-word encoder and program loader
// Define Z16_ENC_RANGE_CHECK_EN to enable immediate/register range checks.
module z16_instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [3:0]        i_opcode,
    input  logic [3:0]        i_rd,
    input  logic [3:0]        i_rs1,
    input  logic [3:0]        i_rs2,
    input  logic [15:0]       i_imm,
    input  logic              i_last,
    output logic              o_mem_wen,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [15:0]       o_mem_wdata,
    input  logic              i_mem_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [1:0]        o_err_code,
    output logic [ADDR_W:0]   o_count
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W:0] CAPACITY = (ADDR_W+1)'(1) << ADDR_W;

    state_t            state;
    logic [15:0]       buf_q [2];
    logic              wr_sel;
    logic              rd_sel;
    logic [1:0]        fill;
    logic [1:0]        fill_next;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   accepted;
    logic              done_q;
    logic              err_q;
    logic [1:0]        err_code_q;

    logic              accept;
    logic              write_done;
    logic              push;
    logic [15:0]       enc_word;
    logic              imm_bad;
    logic              reg_bad;
    logic              cap_bad;
    logic              bad;
    logic [1:0]        bad_code;

    // Ready depends only on registered state, never on i_mem_ready.
    assign o_in_ready  = (state == S_LOAD) && (fill != 2'd2);
    assign o_mem_wen   = (fill != 2'd0);
    assign o_mem_addr  = wr_addr;
    assign o_mem_wdata = buf_q[rd_sel];
    assign o_busy      = (state == S_LOAD) || (state == S_DRAIN);
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_err_code  = err_code_q;
    assign o_count     = count;

    assign accept     = i_in_valid && o_in_ready;
    assign write_done = o_mem_wen && i_mem_ready;
    assign push       = accept && !bad;
    assign fill_next  = fill + {1'b0, push} - {1'b0, write_done};

    always_comb begin
        enc_word = {i_rs2, i_rs1, i_rd, i_opcode};
        case (i_opcode)
            4'h9:                enc_word = {i_imm[7:0], i_rd, i_opcode};
            4'hA, 4'hC, 4'hD:    enc_word = {i_imm[3:0], i_rs1, i_rd, i_opcode};
            4'hB:                enc_word = {i_rs2, i_rs1, i_imm[3:0], i_opcode};
            4'hE, 4'hF:          enc_word = {i_imm[7:0], i_rs2[1:0], i_rs1[1:0], i_opcode};
            default:             enc_word = {i_rs2, i_rs1, i_rd, i_opcode};
        endcase
    end

`ifdef Z16_ENC_RANGE_CHECK_EN
    logic imm8_op;
    logic imm4_op;
    logic reg2_op;

    assign imm8_op = (i_opcode == 4'h9) || (i_opcode == 4'hE) || (i_opcode == 4'hF);
    assign imm4_op = (i_opcode >= 4'hA) && (i_opcode <= 4'hD);
    assign reg2_op = (i_opcode == 4'hE) || (i_opcode == 4'hF);
    // Sign-extension check: the dropped upper bits must all match the slot's sign bit.
    assign imm_bad = (imm8_op && !((&i_imm[15:7]) || !(|i_imm[15:7]))) ||
                     (imm4_op && !((&i_imm[15:3]) || !(|i_imm[15:3])));
    assign reg_bad = reg2_op && ((|i_rs1[3:2]) || (|i_rs2[3:2]));
`else
    logic unused_imm_hi;

    assign unused_imm_hi = ^i_imm[15:8];
    assign imm_bad       = 1'b0;
    assign reg_bad       = 1'b0;
`endif

    assign cap_bad  = (accepted == CAPACITY);
    assign bad      = imm_bad || reg_bad || cap_bad;
    assign bad_code = imm_bad ? 2'b01 : (reg_bad ? 2'b10 : 2'b11);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b0;
            fill       <= '0;
            wr_addr    <= '0;
            count      <= '0;
            accepted   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
        end else begin
            if (push) begin
                buf_q[wr_sel] <= enc_word;
                wr_sel        <= ~wr_sel;
                accepted      <= accepted + 1'b1;
            end
            if (write_done) begin
                rd_sel  <= ~rd_sel;
                wr_addr <= wr_addr + 1'b1;
                count   <= count + 1'b1;
            end
            fill <= fill_next;

            case (state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        state      <= S_LOAD;
                        wr_addr    <= i_base_addr;
                        count      <= '0;
                        accepted   <= '0;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        err_code_q <= '0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (bad) begin
                            err_q      <= 1'b1;
                            err_code_q <= bad_code;
                            state      <= S_DRAIN;
                        end else if (i_last) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (fill_next == 2'd0) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_z16_instr_encoder.sv
// tb/tb_z16_instr_encoder.sv - scoreboard bench for z16_instr_encoder
module tb_z16_instr_encoder;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  opcode = '0, rd = '0, rs1 = '0, rs2 = '0;
    logic [15:0] imm = '0;
    logic        last = 1'b0;
    logic        mem_wen;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready = 1'b1;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [8:0]  count;

    logic        c_start = 1'b0;
    logic [1:0]  c_base = '0;
    logic        c_valid = 1'b0;
    logic        c_ready, c_wen, c_busy, c_done, c_err;
    logic [1:0]  c_addr, c_code;
    logic [15:0] c_wdata;
    logic [2:0]  c_count;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    sb_t         q[$];
    sb_t         cq[$];
    int          wr_cycles[$];
    logic [7:0]  exp_addr = '0;
    logic [1:0]  c_exp_addr = '0;
    logic        stalled = 1'b0;
    logic [7:0]  prev_addr;
    logic [15:0] prev_data;

    always #5 clk = ~clk;

    z16_instr_encoder #(.ADDR_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_base_addr(base),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_opcode(opcode), .i_rd(rd),
        .i_rs1(rs1), .i_rs2(rs2), .i_imm(imm), .i_last(last),
        .o_mem_wen(mem_wen), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_ready(mem_ready), .o_busy(busy), .o_done(done), .o_err(err),
        .o_err_code(err_code), .o_count(count)
    );

    z16_instr_encoder #(.ADDR_W(2)) dut_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(c_start), .i_base_addr(c_base),
        .i_in_valid(c_valid), .o_in_ready(c_ready), .i_opcode(opcode), .i_rd(rd),
        .i_rs1(rs1), .i_rs2(rs2), .i_imm(imm), .i_last(last),
        .o_mem_wen(c_wen), .o_mem_addr(c_addr), .o_mem_wdata(c_wdata),
        .i_mem_ready(mem_ready), .o_busy(c_busy), .o_done(c_done), .o_err(c_err),
        .o_err_code(c_code), .o_count(c_count)
    );

    always @(negedge clk) begin
        sb_t e;
        cyc = cyc + 1;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                if (mem_addr !== prev_addr || mem_wdata !== prev_data) begin
                    failures++;
                    $display("FAIL stall_hold got %h:%h want %h:%h", mem_addr, mem_wdata, prev_addr, prev_data);
                end
            end
            if (mem_wen && mem_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write got %h:%h want none", mem_addr, mem_wdata);
                end else begin
                    e = q.pop_front();
                    if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                        failures++;
                        $display("FAIL write got %h:%h want %h:%h", mem_addr, mem_wdata, e.addr, e.data);
                    end
                    wr_cycles.push_back(cyc);
                end
            end
            stalled   = mem_wen && !mem_ready;
            prev_addr = mem_addr;
            prev_data = mem_wdata;
            if (c_wen && mem_ready) begin
                checks++;
                if (cq.size() == 0) begin
                    failures++;
                    $display("FAIL small_unexpected_write got %h:%h want none", c_addr, c_wdata);
                end else begin
                    e = cq.pop_front();
                    if ({6'b0, c_addr} !== e.addr || c_wdata !== e.data) begin
                        failures++;
                        $display("FAIL small_write got %h:%h want %h:%h", c_addr, c_wdata, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic begin_session(input logic sel, input logic [7:0] b);
        @(posedge clk); #1;
        if (sel) begin c_start = 1'b1; c_base = b[1:0]; c_exp_addr = b[1:0]; end
        else begin start = 1'b1; base = b; exp_addr = b; end
        @(posedge clk); #1;
        start = 1'b0;
        c_start = 1'b0;
    endtask

    task automatic send(input logic sel, input logic [3:0] op, input logic [3:0] d,
                        input logic [3:0] s1, input logic [3:0] s2, input logic [15:0] im,
                        input logic lst, input logic wr, input logic [15:0] exp);
        int n;
        logic rdy;
        opcode = op; rd = d; rs1 = s1; rs2 = s2; imm = im; last = lst;
        if (sel) c_valid = 1'b1; else in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            rdy = sel ? c_ready : in_ready;
            n++;
        end while (!rdy && n < 100);
        if (!rdy) begin
            checks++; failures++;
            $display("FAIL send_timeout got ready=0 want ready=1");
        end else if (wr) begin
            if (sel) begin cq.push_back('{addr: {6'b0, c_exp_addr}, data: exp}); c_exp_addr++; end
            else begin q.push_back('{addr: exp_addr, data: exp}); exp_addr++; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        c_valid = 1'b0;
    endtask

    task automatic wait_done(input logic sel);
        int n = 0;
        logic d;
        do begin
            @(negedge clk);
            d = sel ? c_done : done;
            n++;
        end while (!d && n < 50);
        checks++;
        if (!d) begin
            failures++;
            $display("FAIL done_timeout got done=0 want done=1");
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, mem_wen, mem_addr, mem_wdata, busy, done, err, err_code, count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got %b/%b/%h/%h/%b/%b/%b/%b/%0d want all zero",
                     in_ready, mem_wen, mem_addr, mem_wdata, busy, done, err, err_code, count);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        begin_session(0, 8'h10);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_state got busy=%b ready=%b want 1/1", busy, in_ready);
        end
        send(0, 4'h0, 4'd1, 4'd2, 4'd3, 16'h0, 1'b1, 1'b1, 16'h3210);
        wait_done(0);
        checks++;
        if (count !== 9'd1 || busy !== 1'b0 || err !== 1'b0 || q.size() != 0) begin
            failures++;
            $display("FAIL basic_end got count=%0d busy=%b err=%b pend=%0d want 1/0/0/0", count, busy, err, q.size());
        end
    endtask

    task automatic test_back_to_back;
        wr_cycles.delete();
        begin_session(0, 8'h20);
        send(0, 4'h9, 4'd5, 4'd0, 4'd0, 16'hFFFF, 1'b0, 1'b1, 16'hFF59);
        send(0, 4'hB, 4'd0, 4'd2, 4'd3, 16'hFFFE, 1'b0, 1'b1, 16'h32EB);
        send(0, 4'hE, 4'd0, 4'd1, 4'd2, 16'h0010, 1'b1, 1'b1, 16'h109E);
        wait_done(0);
        checks++;
        if (wr_cycles.size() != 3 || (wr_cycles[$] - wr_cycles[0]) != 2) begin
            failures++;
            $display("FAIL throughput got writes=%0d want 3 in consecutive cycles", wr_cycles.size());
        end
        checks++;
        if (count !== 9'd3 || q.size() != 0) begin
            failures++;
            $display("FAIL stream_count got %0d pend=%0d want 3/0", count, q.size());
        end
    endtask

    task automatic test_stall;
        begin_session(0, 8'h40);
        mem_ready = 1'b0;
        send(0, 4'h1, 4'd1, 4'd1, 4'd1, 16'h0, 1'b0, 1'b1, 16'h1111);
        send(0, 4'h2, 4'd2, 4'd2, 4'd2, 16'h0, 1'b0, 1'b1, 16'h2222);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || mem_wen !== 1'b1) begin
                failures++;
                $display("FAIL stall_full got ready=%b wen=%b want 0/1", in_ready, mem_wen);
            end
        end
        @(posedge clk); #1;
        mem_ready = 1'b1;
        send(0, 4'h3, 4'd3, 4'd3, 4'd3, 16'h0, 1'b1, 1'b1, 16'h3333);
        wait_done(0);
        checks++;
        if (count !== 9'd3 || q.size() != 0) begin
            failures++;
            $display("FAIL stall_count got %0d pend=%0d want 3/0", count, q.size());
        end
    endtask

    task automatic test_range;
`ifdef Z16_ENC_RANGE_CHECK_EN
        begin_session(0, 8'h70);
        send(0, 4'hA, 4'd1, 4'd2, 4'd0, 16'h0008, 1'b1, 1'b0, 16'h0);
        wait_done(0);
        checks++;
        if (err !== 1'b1 || err_code !== 2'b01 || count !== 9'd0) begin
            failures++;
            $display("FAIL imm_range got err=%b code=%b count=%0d want 1/01/0", err, err_code, count);
        end
        begin_session(0, 8'h80);
        send(0, 4'h0, 4'd1, 4'd2, 4'd3, 16'h0, 1'b0, 1'b1, 16'h3210);
        send(0, 4'hE, 4'd0, 4'd4, 4'd0, 16'h0, 1'b0, 1'b0, 16'h0);
        wait_done(0);
        checks++;
        if (err !== 1'b1 || err_code !== 2'b10 || count !== 9'd1 || q.size() != 0) begin
            failures++;
            $display("FAIL reg_range got err=%b code=%b count=%0d want 1/10/1", err, err_code, count);
        end
`else
        begin_session(0, 8'h70);
        send(0, 4'hA, 4'd1, 4'd2, 4'd0, 16'h0008, 1'b1, 1'b1, 16'h821A);
        wait_done(0);
        checks++;
        if (err !== 1'b0 || err_code !== 2'b00 || count !== 9'd1 || q.size() != 0) begin
            failures++;
            $display("FAIL truncate got err=%b code=%b count=%0d want 0/00/1", err, err_code, count);
        end
`endif
    endtask

    task automatic test_capacity;
        begin_session(1, 8'h03);
        for (int i = 0; i < 5; i++)
            send(1, 4'h0, 4'(i), 4'd0, 4'd0, 16'h0, 1'b0, i < 4, 16'(i << 4));
        wait_done(1);
        checks++;
        if (c_err !== 1'b1 || c_code !== 2'b11 || c_count !== 3'd4 || cq.size() != 0) begin
            failures++;
            $display("FAIL capacity got err=%b code=%b count=%0d pend=%0d want 1/11/4/0",
                     c_err, c_code, c_count, cq.size());
        end
    endtask

    task automatic test_reset_midstream;
        begin_session(0, 8'h50);
        mem_ready = 1'b0;
        send(0, 4'h4, 4'd4, 4'd4, 4'd4, 16'h0, 1'b0, 1'b1, 16'h4444);
        send(0, 4'h5, 4'd5, 4'd5, 4'd5, 16'h0, 1'b0, 1'b1, 16'h5555);
        @(negedge clk);
        checks++;
        if (mem_wen !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL buffered got wen=%b busy=%b want 1/1", mem_wen, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        q.delete();
        @(negedge clk);
        checks++;
        if ({in_ready, mem_wen, mem_addr, mem_wdata, busy, done, err, err_code, count} !== '0) begin
            failures++;
            $display("FAIL midreset got %b/%b/%h/%h/%b/%b/%b/%b/%0d want all zero",
                     in_ready, mem_wen, mem_addr, mem_wdata, busy, done, err, err_code, count);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        begin_session(0, 8'h60);
        send(0, 4'h1, 4'd4, 4'd5, 4'd6, 16'h0, 1'b1, 1'b1, 16'h6541);
        wait_done(0);
        checks++;
        if (count !== 9'd1 || err !== 1'b0 || q.size() != 0) begin
            failures++;
            $display("FAIL fresh_session got count=%0d err=%b pend=%0d want 1/0/0", count, err, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_range();
        test_capacity();
        test_reset_midstream();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
